// File: rtl/adc_spi_cap_if.sv
// adc_spi_cap_if: control and SPI signals of the ADC capture block.
interface adc_spi_cap_if #(parameter int ADC_RES = 12);
  logic start, cont, miso, sclk, cs_n, data_valid, busy;
  logic [ADC_RES-1:0] data_out;
  modport master(input start, cont, miso, output sclk, cs_n, data_out, data_valid, busy);
  modport slave(output start, cont, miso, input sclk, cs_n, data_out, data_valid, busy);
endinterface

// File: rtl/adc_spi_cap.sv
// adc_spi_cap: SPI ADC sampler framing lead/data/trail SCLK periods under cs_n.
// Define ADC_SPI_CAP_CONT_EN to let cont chain conversions straight out of QUIET.
module adc_spi_cap #(
  parameter int CLK_DIV = 4,
  parameter int ADC_RES = 12,
  parameter int LEAD_BITS = 3,
  parameter int TRAIL_BITS = 1,
  parameter int QUIET_CYCLES = 16,
  parameter int MISO_INV = 0
) (
  input logic clk,
  input logic reset,
  adc_spi_cap_if.master bus
);
  typedef enum logic [2:0] {IDLE, LEAD, DATA, TRAIL, QUIET} state_t;
  localparam state_t FIRST = LEAD_BITS != 0 ? LEAD : DATA;
  localparam state_t AFTER_DATA = TRAIL_BITS != 0 ? TRAIL : QUIET;
  localparam logic [7:0] DIV_L = 8'(CLK_DIV - 1);
  localparam logic [7:0] Q_L = 8'(QUIET_CYCLES - 1);
  localparam logic [4:0] LEAD_L = 5'(LEAD_BITS - 1);
  localparam logic [4:0] RES_L = 5'(ADC_RES - 1);
  localparam logic [4:0] TRAIL_L = 5'(TRAIL_BITS - 1);
  localparam bit INV = MISO_INV != 0;
`ifdef ADC_SPI_CAP_CONT_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif
  state_t state, next;
  logic [7:0] div, div_d, qcnt, qcnt_d;
  logic [4:0] cnt, cnt_d;
  logic [ADC_RES-1:0] shadow, shadow_d, data_d;
  logic active, tick, rise, pend, last, sclk_d, cs_n_d, valid_d, busy_d;
  assign active = state inside {LEAD, DATA, TRAIL};
  assign tick = active && div == DIV_L;
  assign rise = tick && !bus.sclk;
  // a period ends on the tick that drops sclk back low
  assign pend = tick && bus.sclk;
  assign last = cnt == (state == LEAD ? LEAD_L : state == DATA ? RES_L : TRAIL_L);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = bus.start ? FIRST : IDLE;
      LEAD: next = pend && last ? DATA : LEAD;
      DATA: next = pend && last ? AFTER_DATA : DATA;
      TRAIL: next = pend && last ? QUIET : TRAIL;
      QUIET: next = qcnt == Q_L ? (CONT_EN && bus.cont ? FIRST : IDLE) : QUIET;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    div_d = active && !tick ? div + 8'd1 : 8'd0;
    sclk_d = active && (bus.sclk ^ tick);
    cnt_d = next != state ? 5'd0 : pend ? cnt + 5'd1 : cnt;
    qcnt_d = state == QUIET && next == QUIET ? qcnt + 8'd1 : 8'd0;
    cs_n_d = !(next inside {LEAD, DATA, TRAIL});
    busy_d = next != IDLE;
    shadow_d = state == DATA && rise ? ADC_RES'({shadow, bus.miso ^ INV}) : shadow;
    valid_d = next == QUIET && state != QUIET;
    data_d = valid_d ? shadow : bus.data_out;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      div <= '0;
      qcnt <= '0;
      cnt <= '0;
      shadow <= '0;
      bus.sclk <= 1'b0;
      bus.cs_n <= 1'b1;
      bus.data_out <= '0;
      bus.data_valid <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      div <= div_d;
      qcnt <= qcnt_d;
      cnt <= cnt_d;
      shadow <= shadow_d;
      bus.sclk <= sclk_d;
      bus.cs_n <= cs_n_d;
      bus.data_out <= data_d;
      bus.data_valid <= valid_d;
      bus.busy <= busy_d;
    end
endmodule

// File: tb/tb_adc_spi_cap.sv
// tb_adc_spi_cap: three configurations driven by a bit-indexed ADC model with random sample words.
module tb_adc_spi_cap;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cont = 1'b0;
  int checks = 0, errors = 0;
`ifdef ADC_SPI_CAP_CONT_EN
  localparam int EXP_CONV = 3;
`else
  localparam int EXP_CONV = 1;
`endif
  always #5 clk = ~clk;
  adc_spi_cap_if #(.ADC_RES(12)) bus0();
  adc_spi_cap_if #(.ADC_RES(12)) bus1();
  adc_spi_cap_if #(.ADC_RES(8)) bus2();
  adc_spi_cap #(.CLK_DIV(2), .ADC_RES(12), .LEAD_BITS(3), .TRAIL_BITS(1), .QUIET_CYCLES(16), .MISO_INV(0))
    u0 (.clk(clk), .reset(reset), .bus(bus0));
  adc_spi_cap #(.CLK_DIV(2), .ADC_RES(12), .LEAD_BITS(3), .TRAIL_BITS(1), .QUIET_CYCLES(16), .MISO_INV(1))
    u1 (.clk(clk), .reset(reset), .bus(bus1));
  adc_spi_cap #(.CLK_DIV(1), .ADC_RES(8), .LEAD_BITS(0), .TRAIL_BITS(0), .QUIET_CYCLES(16), .MISO_INV(0))
    u2 (.clk(clk), .reset(reset), .bus(bus2));
  assign bus0.start = start;
  assign bus1.start = start;
  assign bus2.start = start;
  assign bus0.cont = cont;
  assign bus1.cont = cont;
  assign bus2.cont = cont;
  // ADC model: after r sclk rises the wire carries sample bit r-lead, MSB first; ones elsewhere
  logic [15:0] word0 = '0, word2 = '0;
  int r0 = 0, r2 = 0;
  logic ps0 = 1'b0, ps2 = 1'b0;
  function automatic logic adc_bit(input logic [15:0] w, input int res, input int lead, input int r);
    return (r >= lead && r < lead + res) ? w[res - 1 - (r - lead)] : 1'b1;
  endfunction
  assign bus0.miso = adc_bit(word0, 12, 3, r0);
  assign bus1.miso = bus0.miso;
  assign bus2.miso = adc_bit(word2, 8, 0, r2);
  always @(negedge clk) begin
    r0 <= bus0.cs_n ? 0 : r0 + int'(bus0.sclk && !ps0);
    r2 <= bus2.cs_n ? 0 : r2 + int'(bus2.sclk && !ps2);
    ps0 <= bus0.sclk;
    ps2 <= bus2.sclk;
  end
  logic [2:0] cs, sc, dv, bz;
  logic [15:0] dout [3];
  assign cs = {bus2.cs_n, bus1.cs_n, bus0.cs_n};
  assign sc = {bus2.sclk, bus1.sclk, bus0.sclk};
  assign dv = {bus2.data_valid, bus1.data_valid, bus0.data_valid};
  assign bz = {bus2.busy, bus1.busy, bus0.busy};
  assign dout[0] = 16'(bus0.data_out);
  assign dout[1] = 16'(bus1.data_out);
  assign dout[2] = 16'(bus2.data_out);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic conv(input logic [15:0] w0, input logic [15:0] w2);
    int low[3], ris[3], nv[3], el[3], er[3], n;
    logic [15:0] cap[3], pd[3], ed[3];
    logic held[3], psc[3];
    word0 = w0;
    word2 = w2;
    el = '{64, 64, 16};
    er = '{16, 16, 8};
    ed[0] = {4'h0, w0[11:0]};
    ed[1] = {4'h0, ~w0[11:0]};
    ed[2] = {8'h0, w2[7:0]};
    for (int i = 0; i < 3; i++) begin
      low[i] = 0; ris[i] = 0; nv[i] = 0; cap[i] = '0; pd[i] = dout[i]; held[i] = 1'b1; psc[i] = 1'b0;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    do begin
      for (int i = 0; i < 3; i++) begin
        if (!cs[i]) low[i]++;
        if (sc[i] && !psc[i]) ris[i]++;
        psc[i] = sc[i];
        if (dv[i]) begin
          nv[i]++;
          cap[i] = dout[i];
        end else if (nv[i] == 0 && dout[i] != pd[i]) held[i] = 1'b0;
      end
      n++;
      @(negedge clk);
    end while ((bz[0] || bz[2]) && n < 400);
    chk("conv_timeout", 32'(n < 400), 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cs_low%0d", i), low[i], el[i]);
      chk($sformatf("rises%0d", i), ris[i], er[i]);
      chk($sformatf("valid_cnt%0d", i), nv[i], 1);
      chk($sformatf("data%0d", i), cap[i], ed[i]);
      chk($sformatf("hold%0d", i), held[i], 1);
    end
  endtask
  initial begin
    int n, g, k, f, gh;
    logic p, pcs;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i += 2) begin
      chk($sformatf("rst_cs%0d", i), cs[i], 1);
      chk($sformatf("rst_sclk%0d", i), sc[i], 0);
      chk($sformatf("rst_data%0d", i), dout[i], 0);
      chk($sformatf("rst_valid%0d", i), dv[i], 0);
      chk($sformatf("rst_busy%0d", i), bz[i], 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    conv(16'ha5c, 16'hff);
    repeat (4) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      conv(16'($urandom), 16'($urandom));
    end
    start = 1'b1;
    n = 0;
    while (cs[0] && n < 100) begin @(negedge clk); n++; end
    while (!cs[0] && n < 300) begin @(negedge clk); n++; end
    g = 0;
    while (cs[0] && g < 100) begin g++; @(negedge clk); end
    chk("gap_start_held", g, 17);
    start = 1'b0;
    n = 0;
    while ((bz[0] || bz[2]) && n < 400) begin @(negedge clk); n++; end
    chk("held_idle", bz[0], 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; k = 0; p = 1'b0;
    while (k < 8 && n < 300) begin
      if (sc[0] && !p) k++;
      p = sc[0];
      @(negedge clk);
      n++;
    end
    chk("pre_reset_busy", bz[0], 1);
    #1 reset = 1'b1;
    #1;
    chk("abort_cs", cs[0], 1);
    chk("abort_sclk", sc[0], 0);
    chk("abort_data", dout[0], 0);
    chk("abort_busy", bz[0], 0);
    @(negedge clk);
    reset = 1'b0;
    k = 0; g = 0;
    repeat (150) begin
      if (dv[0]) k++;
      if (!cs[0]) g++;
      @(negedge clk);
    end
    chk("abort_valid", k, 0);
    chk("abort_idle", g, 0);
    word0 = 16'ha5c;
    cont = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    f = 0; gh = 0; pcs = 1'b1;
    repeat (400) begin
      if (pcs && !cs[0]) begin
        f++;
        if (f > 1) chk("gap_cont", gh, 16);
        if (f == 3) cont = 1'b0;
      end
      gh = cs[0] ? gh + 1 : 0;
      pcs = cs[0];
      @(negedge clk);
    end
    cont = 1'b0;
    chk("conv_count", f, EXP_CONV);
    chk("cont_data", dout[0], 16'ha5c);
    chk("cont_idle", bz[0], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_spi_cap.md
ADC_SPI_CAP -- requirements
Module: adc_spi_cap

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK half-period, legal 1..255.
REQ-002 The block SHALL have parameter ADC_RES, default 12: data bits per conversion, legal 1..16.
REQ-003 The block SHALL have parameter LEAD_BITS, default 3: discarded SCLK periods before data, legal 0..7.
REQ-004 The block SHALL have parameter TRAIL_BITS, default 1: discarded SCLK periods after data, legal 0..7.
REQ-005 The block SHALL have parameter QUIET_CYCLES, default 16: minimum clk cycles with cs_n high between conversions, legal 1..255.
REQ-006 The block SHALL have parameter MISO_INV, default 0: 1 means miso is inverted before capture.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge clk.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port start, input, 1 bit: conversion request, level-sampled in IDLE.
REQ-010 The block SHALL have port cont, input, 1 bit: continuous-mode request (see Configuration).
REQ-011 The block SHALL have port miso, input, 1 bit: ADC serial data.
REQ-012 The block SHALL have port sclk, output, 1 bit: SPI clock, idle low.
REQ-013 The block SHALL have port cs_n, output, 1 bit: ADC chip select, active low.
REQ-014 The block SHALL have port data_out, output, ADC_RES bits: last completed sample, MSB first on the wire.
REQ-015 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_out updates.
REQ-016 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, LEAD, DATA, TRAIL, QUIET; all outputs SHALL be registered.
REQ-018 In IDLE with start=1, the next cycle SHALL be state LEAD with cs_n=0 and sclk=0; if LEAD_BITS=0, the FSM SHALL enter DATA directly.
REQ-019 In LEAD, DATA and TRAIL, sclk SHALL toggle every CLK_DIV clk cycles, starting low, giving one SCLK period per 2*CLK_DIV cycles.
REQ-020 The FSM SHALL count SCLK periods per state: LEAD_BITS, then ADC_RES, then TRAIL_BITS; a state whose count is 0 SHALL be skipped.
REQ-021 In DATA, miso (XOR MISO_INV) SHALL be sampled on the clk cycle that drives sclk rising and shifted into a shadow register, MSB first.
REQ-022 At the end of the last SCLK period of the final non-empty state, sclk SHALL be 0 and cs_n SHALL go to 1.
REQ-023 On that same cycle, data_out SHALL load the shadow register, data_valid SHALL pulse for 1 cycle, and the FSM SHALL enter QUIET.
REQ-024 cs_n SHALL be low for exactly (LEAD_BITS+ADC_RES+TRAIL_BITS)*2*CLK_DIV clk cycles per conversion.
REQ-025 QUIET SHALL last exactly QUIET_CYCLES cycles and then return to IDLE; start SHALL be ignored outside IDLE, with no queuing.
REQ-026 data_out SHALL hold its value between data_valid pulses, including while busy.

Reset
REQ-027 While reset=1, asynchronously: cs_n=1, sclk=0, data_out=0, data_valid=0, busy=0, state=IDLE, all counters and the shadow register SHALL be 0.
REQ-028 A reset asserted mid-conversion SHALL abort it with no data_valid pulse; after release, the FSM SHALL wait in IDLE for start.

Configuration
REQ-029 When macro ADC_SPI_CAP_CONT_EN is defined, QUIET with cont=1 SHALL go to LEAD (or DATA) instead of IDLE, starting back-to-back conversions spaced by QUIET_CYCLES.
REQ-030 When ADC_SPI_CAP_CONT_EN is undefined, the cont port SHALL exist but be ignored, and QUIET SHALL always go to IDLE.

Verification
REQ-031 Basic: CLK_DIV=2, ADC_RES=12, LEAD=3, TRAIL=1, miso model returns 0xA5C; pulse start -> cs_n low for 64 cycles, 16 sclk rising edges, data_out=0xA5C, one data_valid pulse.
REQ-032 Inversion: MISO_INV=1 with the same model -> data_out=0x5A3.
REQ-033 Edge counts: LEAD=0, TRAIL=0, ADC_RES=8, CLK_DIV=1, miso=0xFF -> cs_n low for 16 cycles, data_out=0xFF.
REQ-034 Busy/ignore: start held high across the conversion -> the next cs_n fall occurs exactly QUIET_CYCLES+1 cycles after cs_n rises.
REQ-035 Reset mid-DATA after 5 bits -> cs_n=1 and sclk=0 in the same cycle, data_out stays at its prior value or 0, no data_valid pulse.
REQ-036 With ADC_SPI_CAP_CONT_EN, cont=1 and a single start -> 3 conversions with cs_n high gaps of QUIET_CYCLES each; with the macro undefined -> only 1 conversion.
